// File: rtl/panel_scan_engine.sv
// Front-panel scanner: LED matrix multiplexing, switch matrix scan, per-key debounce, toggle emulation.
// Optional macro PANEL_SCAN_BLANK_EN inserts a blanking step before every lit LED row.
module panel_scan_engine #(
    parameter int LED_ROWS = 3,
    parameter int LED_COLS = 13,
    parameter int SW_ROWS  = 6,
    parameter int SW_COLS  = 4,
    parameter int SCAN_DIV = 32768,
    parameter int DEBOUNCE = 3,
    parameter logic [SW_ROWS*SW_COLS-1:0] TOGGLE_MASK = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [LED_ROWS*LED_COLS-1:0] led_data,
    output logic [LED_ROWS-1:0]          led_row,
    output logic [LED_COLS-1:0]          led_col,
    output logic [SW_ROWS-1:0]           sw_row,
    input  logic [SW_COLS-1:0]           sw_col,
    output logic [SW_ROWS*SW_COLS-1:0]   sw_state,
    output logic [SW_ROWS*SW_COLS-1:0]   sw_press,
    output logic                         scan_tick
);

    localparam int NK  = SW_ROWS * SW_COLS;
    localparam int PW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int LIW = (LED_ROWS > 1) ? $clog2(LED_ROWS) : 1;
    localparam int SIW = (SW_ROWS > 1) ? $clog2(SW_ROWS) : 1;
    localparam logic [LED_ROWS-1:0] LED_ONE = 1;
    localparam logic [SW_ROWS-1:0]  SW_ONE  = 1;

    logic [PW-1:0]  presc;
    logic           term;
    logic [LIW-1:0] led_idx;
    logic [SIW-1:0] sw_idx;
    logic [SIW-1:0] sw_idx_nxt;
    logic [3:0]     db_cnt   [NK];
    logic [3:0]     db_cnt_n [NK];
    logic [NK-1:0]  db_val;
    logic [NK-1:0]  db_val_n;
    logic [NK-1:0]  rise_n;

    assign term = (presc == PW'(SCAN_DIV - 1));

    // Prescaler and registered step pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc     <= '0;
            scan_tick <= 1'b0;
        end else begin
            presc     <= term ? '0 : presc + PW'(1);
            scan_tick <= term;
        end
    end

`ifdef PANEL_SCAN_BLANK_EN
    logic led_lit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_idx <= '0;
            led_row <= '0;
            led_col <= '0;
            led_lit <= 1'b0;
        end else if (term) begin
            // Alternate blank step / lit step so row drivers settle with columns off
            if (!led_lit) begin
                led_row <= '0;
                led_col <= '0;
            end else begin
                led_row <= LED_ONE << led_idx;
                led_col <= led_data[int'(led_idx)*LED_COLS +: LED_COLS];
                led_idx <= (led_idx == LIW'(LED_ROWS - 1)) ? '0 : led_idx + LIW'(1);
            end
            led_lit <= ~led_lit;
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_idx <= '0;
            led_row <= '0;
            led_col <= '0;
        end else if (term) begin
            led_row <= LED_ONE << led_idx;
            led_col <= led_data[int'(led_idx)*LED_COLS +: LED_COLS];
            led_idx <= (led_idx == LIW'(LED_ROWS - 1)) ? '0 : led_idx + LIW'(1);
        end
    end
`endif

    assign sw_idx_nxt = (sw_idx == SIW'(SW_ROWS - 1)) ? '0 : sw_idx + SIW'(1);

    // Debounce: only keys of the currently driven row see a sample, once per step
    always_comb begin
        db_val_n = db_val;
        rise_n   = '0;
        for (int k = 0; k < NK; k++) begin
            db_cnt_n[k] = db_cnt[k];
            if (term && ((k / SW_COLS) == int'(sw_idx))) begin
                if (sw_col[k % SW_COLS] == db_val[k]) begin
                    db_cnt_n[k] = '0;
                end else if ((db_cnt[k] + 4'd1) == 4'(DEBOUNCE)) begin
                    db_cnt_n[k] = '0;
                    db_val_n[k] = ~db_val[k];
                    rise_n[k]   = ~db_val[k];
                end else begin
                    db_cnt_n[k] = db_cnt[k] + 4'd1;
                end
            end
        end
    end

    // Switch row drive, debounce state and key outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_idx   <= '0;
            sw_row   <= SW_ONE;
            db_val   <= '0;
            sw_state <= '0;
            sw_press <= '0;
            for (int k = 0; k < NK; k++) db_cnt[k] <= '0;
        end else begin
            if (term) begin
                sw_idx <= sw_idx_nxt;
                sw_row <= SW_ONE << sw_idx_nxt;
            end
            db_val   <= db_val_n;
            sw_press <= rise_n;
            sw_state <= (TOGGLE_MASK & (sw_state ^ rise_n)) | (~TOGGLE_MASK & db_val_n);
            for (int k = 0; k < NK; k++) db_cnt[k] <= db_cnt_n[k];
        end
    end

endmodule

// File: tb/tb_panel_scan_engine.sv
// Directed bench for panel_scan_engine: 3x4 LED matrix, 2x2 keys, 4-clk steps, debounce of 2.
module tb_panel_scan_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] led_data = '0;
    logic [2:0]  led_row;
    logic [3:0]  led_col;
    logic [1:0]  sw_row;
    logic [1:0]  sw_col;
    logic [3:0]  sw_state;
    logic [3:0]  sw_press;
    logic        scan_tick;
    logic [3:0]  keys = '0;

    int n_checks = 0;
    int n_errors = 0;
    int tick_n   = 0;

    panel_scan_engine #(
        .LED_ROWS(3), .LED_COLS(4), .SW_ROWS(2), .SW_COLS(2),
        .SCAN_DIV(4), .DEBOUNCE(2), .TOGGLE_MASK(4'b0010)
    ) dut (
        .clk(clk), .reset(reset), .led_data(led_data),
        .led_row(led_row), .led_col(led_col),
        .sw_row(sw_row), .sw_col(sw_col),
        .sw_state(sw_state), .sw_press(sw_press), .scan_tick(scan_tick)
    );

    always #5 clk = ~clk;

    // Physical key matrix: a pressed key connects its driven row to its column
    always_comb begin
        sw_col = '0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                if (sw_row[r] && keys[r*2+c]) sw_col[c] = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wait_tick(output int cycles);
        cycles = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            cycles++;
            if (scan_tick) break;
        end
        tick_n++;
        if (!scan_tick) chk($sformatf("tick_timeout@t%0d", tick_n), 32'd0, 32'd1);
    endtask

    task automatic tick_chk(input logic [3:0] exp_state, input logic [3:0] exp_press);
        int cyc;
        wait_tick(cyc);
        chk($sformatf("state@t%0d", tick_n), 32'(sw_state), 32'(exp_state));
        chk($sformatf("press@t%0d", tick_n), 32'(sw_press), 32'(exp_press));
        if (exp_press != 4'd0) begin
            @(negedge clk);
            chk($sformatf("press_clr@t%0d", tick_n), 32'(sw_press), 32'd0);
        end
    endtask

    initial begin
        int cyc;
        logic [2:0] exp_row;
        logic [3:0] exp_col;
        led_data = 12'hCA5;
        #1 reset = 1'b1;
        #2;
        chk("rst_led_row", 32'(led_row), 32'd0);
        chk("rst_led_col", 32'(led_col), 32'd0);
        chk("rst_sw_row", 32'(sw_row), 32'd1);
        chk("rst_sw_state", 32'(sw_state), 32'd0);
        chk("rst_sw_press", 32'(sw_press), 32'd0);
        chk("rst_tick", 32'(scan_tick), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // LED multiplexing, six steps
        for (int t = 1; t <= 6; t++) begin
            wait_tick(cyc);
            chk($sformatf("tick_period@t%0d", t), 32'(cyc), 32'd4);
`ifdef PANEL_SCAN_BLANK_EN
            if (t % 2 == 1) begin
                exp_row = 3'b000; exp_col = 4'h0;
            end else begin
                case ((t / 2 - 1) % 3)
                    0: begin exp_row = 3'b001; exp_col = 4'h5; end
                    1: begin exp_row = 3'b010; exp_col = 4'hA; end
                    default: begin exp_row = 3'b100; exp_col = 4'hC; end
                endcase
            end
`else
            case ((t - 1) % 3)
                0: begin exp_row = 3'b001; exp_col = 4'h5; end
                1: begin exp_row = 3'b010; exp_col = 4'hA; end
                default: begin exp_row = 3'b100; exp_col = 4'hC; end
            endcase
`endif
            chk($sformatf("led_row@t%0d", t), 32'(led_row), 32'(exp_row));
            chk($sformatf("led_col@t%0d", t), 32'(led_col), 32'(exp_col));
            chk($sformatf("sw_row@t%0d", t), 32'(sw_row), (t % 2 == 1) ? 32'd2 : 32'd1);
        end

        // Normal key 0 (row 0): press after two row-0 samples, silent release
        keys[0] = 1'b1;
        tick_chk(4'h0, 4'h0);
        tick_chk(4'h0, 4'h0);
        tick_chk(4'h1, 4'h1);
        keys[0] = 1'b0;
        tick_chk(4'h1, 4'h0);
        tick_chk(4'h1, 4'h0);
        tick_chk(4'h1, 4'h0);
        tick_chk(4'h0, 4'h0);

        // Toggle key 1: press, release, press
        keys[1] = 1'b1;
        tick_chk(4'h0, 4'h0);
        tick_chk(4'h0, 4'h0);
        tick_chk(4'h0, 4'h0);
        tick_chk(4'h2, 4'h2);
        keys[1] = 1'b0;
        repeat (4) tick_chk(4'h2, 4'h0);
        keys[1] = 1'b1;
        repeat (3) tick_chk(4'h2, 4'h0);
        tick_chk(4'h0, 4'h2);
        keys[1] = 1'b0;
        repeat (4) tick_chk(4'h0, 4'h0);

        // Key 2 (row 1) bounces 1,0,1,1 on its row samples
        keys[2] = 1'b1;
        tick_chk(4'h0, 4'h0);
        tick_chk(4'h0, 4'h0);
        keys[2] = 1'b0;
        tick_chk(4'h0, 4'h0);
        tick_chk(4'h0, 4'h0);
        keys[2] = 1'b1;
        tick_chk(4'h0, 4'h0);
        tick_chk(4'h0, 4'h0);
        tick_chk(4'h4, 4'h4);
        keys[2] = 1'b0;
        repeat (3) tick_chk(4'h4, 4'h0);
        tick_chk(4'h0, 4'h0);

        // Keys 2 and 3 pressed together in row 1
        keys[2] = 1'b1;
        keys[3] = 1'b1;
        repeat (3) tick_chk(4'h0, 4'h0);
        tick_chk(4'hC, 4'hC);
        keys[1] = 1'b1;
        repeat (2) tick_chk(4'hC, 4'h0);
        tick_chk(4'hE, 4'h2);

        // Asynchronous reset mid-step, between clock edges
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_led_row", 32'(led_row), 32'd0);
        chk("mid_rst_led_col", 32'(led_col), 32'd0);
        chk("mid_rst_sw_row", 32'(sw_row), 32'd1);
        chk("mid_rst_sw_state", 32'(sw_state), 32'd0);
        chk("mid_rst_sw_press", 32'(sw_press), 32'd0);
        chk("mid_rst_tick", 32'(scan_tick), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_tick(cyc);
        chk("post_rst_period", 32'(cyc), 32'd4);
        chk("post_rst_state", 32'(sw_state), 32'd0);
        chk("post_rst_press", 32'(sw_press), 32'd0);
`ifdef PANEL_SCAN_BLANK_EN
        chk("post_rst_led_row", 32'(led_row), 32'd0);
`else
        chk("post_rst_led_row", 32'(led_row), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
